// File: rtl/uart_rx.sv
// UART receiver on a 16x oversampled tick; 8N1 by default, valid/ready byte output.
// Define UART_RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_16x_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_s_cnt;
  logic [2:0]             r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [7:0]             r_data;
  logic                   r_valid, r_new, r_frame_err, r_overrun;

  logic w_rx_s, w_mid_start, w_mid_bit, w_last_bit;
  logic w_cnt_clr, w_shift_en, w_stop_ok, w_stop_bad, w_par_bad;
  logic [7:0] w_data_ext;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  logic r_par_bit, r_par_err, w_par_latch;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  assign w_rx_s      = r_sync[SYNC_STAGES-1];
  assign w_mid_start = tick_16x_i && (r_s_cnt == 4'd7);
  assign w_mid_bit   = tick_16x_i && (r_s_cnt == 4'd15);
  assign w_last_bit  = (r_bit_cnt == 3'(DATA_BITS-1));
  assign w_data_ext  = 8'(r_shift);

  // rx_i is asynchronous; everything downstream looks only at w_rx_s
  always_ff @(posedge clk_i) begin
    if (!rst_i) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_rx_s)     w_next = S_START;
      S_START:  if (w_mid_start) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_mid_bit && w_last_bit) w_next = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (w_mid_bit)   w_next = S_STOP;
      S_STOP:   if (w_mid_bit)   w_next = w_rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (w_rx_s)      w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_latch = 1'b0;
`endif
    case (r_state)
      S_IDLE:   w_cnt_clr  = 1'b1;
      S_START:  w_cnt_clr  = w_mid_start;
      S_DATA:   w_shift_en = w_mid_bit;
`ifdef UART_RX_PARITY_EN
      S_PARITY: w_par_latch = w_mid_bit;
`endif
      S_STOP: begin
        w_stop_ok  = w_mid_bit &&  w_rx_s;
        w_stop_bad = w_mid_bit && !w_rx_s;
      end
      S_BREAK:  w_cnt_clr  = 1'b1;
      default:  ;
    endcase
  end

  // s_cnt wraps 15->0 on its own, so each DATA sample lands 16 ticks after the last
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_s_cnt   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_cnt_clr)       r_s_cnt <= '0;
      else if (tick_16x_i) r_s_cnt <= r_s_cnt + 4'd1;
      if (w_shift_en) begin
        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= w_last_bit ? 3'd0 : r_bit_cnt + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign w_par_bad = (r_par_bit != ((^r_shift) ^ PARITY_ODD));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_par_bit <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (w_par_latch) r_par_bit <= w_rx_s;
      r_par_err <= w_stop_ok && w_par_bad;
    end
  end

  assign parity_err_o = r_par_err;
`else
  assign w_par_bad    = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // r_new marks the cycle after the stop-sample tick, where the handshake is resolved
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_new       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
    end else begin
      r_new       <= w_stop_ok && !w_par_bad;
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (r_new && (!r_valid || ready_i)) begin
        r_data  <= w_data_ext;
        r_valid <= 1'b1;
      end else if (r_new) begin
        r_overrun <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

  a_hold: assert property (@(posedge clk_i) disable iff (!rst_i)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
  a_err_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
    frame_err_o |-> !parity_err_o);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: 4-clock tick, 64-clock bit period.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int  BIT_CLKS   = 64;
  localparam bit  PARITY_ODD = 1'b0;

  logic       clk_i = 1'b0, rst_i = 1'b0, tick_16x_i = 1'b0, rx_i = 1'b1, ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, parity_err_o, overrun_o;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
  int act_ferr = 0, act_perr = 0, act_ovr = 0, n_pres = 0;

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2), .PARITY_ODD(PARITY_ODD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_16x_i(tick_16x_i), .rx_i(rx_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    forever begin
      repeat (3) @(negedge clk_i);
      tick_16x_i = 1'b1;
      @(negedge clk_i);
      tick_16x_i = 1'b0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a byte is "presented" when valid rises, or when it stays high across a handshake
  initial begin
    logic       pv, pt;
    logic [7:0] pd;
    pv = 1'b0; pt = 1'b0; pd = '0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) begin
        if (frame_err_o)  act_ferr++;
        if (parity_err_o) act_perr++;
        if (overrun_o)    act_ovr++;
        if (valid_o && (!pv || ready_i)) begin
          n_pres++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_byte: got 0x%0h required no output", data_o);
          end else begin
            check("rx_byte", data_o, exp_q.pop_front());
          end
          if (!pv) check("valid_latency_after_tick", pt, 1);
        end
        if (pv && valid_o && !ready_i) check("data_stable", data_o, pd);
      end
      pv = valid_o; pt = tick_16x_i; pd = data_o;
    end
  end

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  // Reference outcome of one frame, from the frame fields and whether a byte is still unconsumed
  task automatic expect_frame(input logic [7:0] d, input logic par, input logic stop, input logic busy);
    if (!stop) exp_ferr++;
`ifdef UART_RX_PARITY_EN
    else if (par != good_par(d)) exp_perr++;
`endif
    else if (busy) exp_ovr++;
    else exp_q.push_back(d);
  endtask

  task automatic bit_time(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk_i);
  endtask

  task automatic idle_clks(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  // ready_at: frame bit index (0 = start) at which ready_i is raised; -1 leaves ready alone
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int ready_at);
    logic [10:0] bits;
    int nb;
`ifdef UART_RX_PARITY_EN
    bits = {stop, par, d, 1'b0}; nb = 11;
`else
    bits = {1'b0, stop, d, 1'b0}; nb = 10;
    if (par) nb = 10;
`endif
    for (int i = 0; i < nb; i++) begin
      if (i == ready_at) ready_i = 1'b1;
      bit_time(bits[i]);
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic par, input logic stop, input logic busy);
    expect_frame(d, par, stop, busy);
    send_frame(d, par, stop, -1);
    idle_clks(8);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err_count"},  act_ferr, exp_ferr);
    check({tag, "_parity_err_count"}, act_perr, exp_perr);
    check({tag, "_overrun_count"},    act_ovr,  exp_ovr);
  endtask

  initial begin
    int pres0;
    logic [7:0] d;
    logic stop, par;

    repeat (3) @(negedge clk_i);
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_errs", {frame_err_o, parity_err_o, overrun_o}, 0);
    rst_i = 1'b1; ready_i = 1'b1;
    idle_clks(2 * BIT_CLKS);

    // Reset in the middle of a frame aborts it
    bit_time(1'b0); bit_time(1'b1); bit_time(1'b0);
    repeat (20) @(negedge clk_i);
    rst_i = 1'b0; rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("midrst_data", data_o, 0);
    check("midrst_valid", valid_o, 0);
    check("midrst_errs", {frame_err_o, parity_err_o, overrun_o}, 0);
    rst_i = 1'b1;
    idle_clks(2 * BIT_CLKS);
    frame(8'h5A, good_par(8'h5A), 1'b1, 1'b0);
    wait_drain("t1_drain");
    check_counts("t1");

    // Held byte, then a single-cycle handshake
    ready_i = 1'b0;
    frame(8'hA5, good_par(8'hA5), 1'b1, 1'b0);
    wait_drain("t2_drain");
    check("t2_valid_held", valid_o, 1);
    check("t2_data_held", data_o, 8'hA5);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check("t2_valid_cleared", valid_o, 0);
    check("t2_data_kept", data_o, 8'hA5);
    ready_i = 1'b1;

    // Start-bit glitch of 5 ticks
    pres0 = n_pres;
    rx_i = 1'b0;
    repeat (20) @(negedge clk_i);
    idle_clks(2 * BIT_CLKS);
    check("t3_no_output", n_pres, pres0);
    check_counts("t3");

    // Framing error with a line held low, then recovery
    expect_frame(8'h3C, good_par(8'h3C), 1'b0, 1'b0);
    send_frame(8'h3C, good_par(8'h3C), 1'b0, -1);
    rx_i = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk_i);
    idle_clks(BIT_CLKS);
    check_counts("t4_break");
    frame(8'h55, good_par(8'h55), 1'b1, 1'b0);
    wait_drain("t4_drain");
    check_counts("t4");

    // Overrun while the consumer stalls
    ready_i = 1'b0;
    frame(8'h11, good_par(8'h11), 1'b1, 1'b0);
    frame(8'h22, good_par(8'h22), 1'b1, 1'b1);
    wait_drain("t5_drain");
    check("t5_data_kept", data_o, 8'h11);
    check("t5_valid_kept", valid_o, 1);
    check_counts("t5a");
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    frame(8'h11, good_par(8'h11), 1'b1, 1'b0);
    expect_frame(8'h22, good_par(8'h22), 1'b1, 1'b0);
    send_frame(8'h22, good_par(8'h22), 1'b1, 9);
    idle_clks(8);
    wait_drain("t5b_drain");
    check_counts("t5b");

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b1, 1'b0);
    frame(8'h07, 1'b0, 1'b1, 1'b0);
    wait_drain("t6_drain");
    check_counts("t6");
`endif

    // Random frames: data, occasional bad stop / bad parity, random gaps
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(7) != 0);
      par  = ($urandom_range(4) == 0) ? ~good_par(d) : good_par(d);
      expect_frame(d, par, stop, 1'b0);
      send_frame(d, par, stop, -1);
      if (!stop) begin
        rx_i = 1'b0;
        repeat ($urandom_range(BIT_CLKS)) @(negedge clk_i);
      end
      idle_clks(4 + $urandom_range(80));
    end
    wait_drain("rand_drain");
    check_counts("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
